fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single FIFO write port among N producers.
//  Latches the granted producer's word and drives wr_en/data_in for one cycle.
//  Checks the FIFO's wr_ack/overflow response and retries rejected writes.
//  Sits between the producer blocks and the FIFO DUT modport, in the clk domain.
// PARAMETERS
//  FIFO_WIDTH  16  data word width; must match the FIFO
//  N_REQ       4   number of producers, 2..16
//  CNT_W       8   width of the saturating retry counter
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  rst_n        in   1             synchronous, active-low reset
//  req          in   N_REQ         producer k requests a write; held until done[k]
//  req_data     in   N_REQ*W       producer k word at [k*FIFO_WIDTH +: FIFO_WIDTH]
//  grant        out  N_REQ         one-hot owner of the in-flight write, else 0
//  done         out  N_REQ         1-cycle pulse: producer k's word accepted by FIFO
//  data_in      out  FIFO_WIDTH    to FIFO data_in (registered)
//  wr_en        out  1             to FIFO wr_en (registered)
//  wr_ack       in   1             from FIFO: previous-cycle write accepted
//  overflow     in   1             from FIFO: previous-cycle write rejected
//  full         in   1             from FIFO
//  busy         out  1             state != IDLE
//  retry_cnt    out  CNT_W         number of overflow retries, saturates at all-ones
//  proto_err    out  1             sticky: neither wr_ack nor overflow seen in WAIT
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, grant=0, done=0, wr_en=0, data_in=0,
//   rr_ptr=N_REQ-1, retry_cnt=0, proto_err=0. A write in flight is abandoned without
//   a done pulse. Producers re-request after reset.
//  FSM states: IDLE, ISSUE, WAIT, BLOCKED. All outputs are registered.
//   IDLE: if |req && !full -> pick winner k (first req set, searching from rr_ptr+1
//     mod N_REQ upward); grant<=onehot(k); data_in<=req_data[k]; -> ISSUE.
//     If full or no req -> stay IDLE.
//   ISSUE: wr_en=1 for exactly this cycle; -> WAIT.
//   WAIT: wr_en=0; sample the FIFO response:
//     wr_ack=1           -> done[k]<=1 (next cycle), rr_ptr<=k, grant<=0, -> IDLE
//     overflow=1         -> retry_cnt++ (saturate), keep grant/data, -> BLOCKED
//     both 0             -> proto_err<=1; treat as overflow (retry path)
//     both 1             -> treat as wr_ack; proto_err<=1
//   BLOCKED: wait while full; when !full -> ISSUE (same k, same data_in).
//  Latency: req[k] rising in cycle 0 with FIFO not full -> grant in cycle 1,
//   wr_en in cycle 1, done[k] in cycle 3. Throughput: one word per 3 cycles.
//  A producer that drops req after grant still completes; done[k] still pulses.
//  Producer k must not re-request in the cycle after done[k] is high. rr_ptr
//   changes only on an accepted write, so a retried producer keeps its turn.
//  rr_ptr width is $clog2(N_REQ); the wrap is modulo N_REQ, also when N_REQ is
//   not a power of 2.
//  full is sampled only in IDLE and BLOCKED. ISSUE always asserts wr_en. The FIFO's
//   overflow response covers a race where full rises during ISSUE.
// STRUCTURE
//  fifo_arb_pkg: typedef enum logic [1:0] {IDLE,ISSUE,WAIT,BLOCKED} arb_state_e;
//   localparam defaults; function onehot(idx).
//  Sub-module rr_pick #(N_REQ): combinational; inputs req, rr_ptr;
//   outputs valid, idx. Instantiated once. The FSM and registers live in the top.
// TESTING (FIFO_WIDTH=16, FIFO_DEPTH=8, N_REQ=4, reference FIFO model)
//  1 single: req=0001, data0=16'hA5A5 -> wr_en cycle 1, data_in=A5A5; done=0001 cycle 3
//  2 fairness: req=1111 held -> grants in order 0,1,2,3,0; 8 writes, then FIFO full
//  3 full: FIFO holds 8 words, req=0100 -> stays IDLE and wr_en never set; 1 read
//     -> write issues, done=0100
//  4 overflow race: force overflow=1 in WAIT -> BLOCKED, retry_cnt=1, same data
//     reissued, no done until wr_ack
//  5 reset mid-op: rst_n=0 in WAIT -> next cycle all outputs 0, rr_ptr=3, no done
//  6 protocol: hold wr_ack=overflow=0 in WAIT -> proto_err=1 sticky, retry issued

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding, the default parameters and the one-hot decoder.
package fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BLOCKED = 2'd3
    } arb_state_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int N_REQ_DEF      = 4;
    localparam int CNT_W_DEF      = 8;
    localparam int MAX_REQ        = 16;

    // Sized for the largest legal N_REQ; callers truncate to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        onehot = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
// The master modport is the arbiter; the slave modport is the producers plus FIFO.
interface fifo_wr_arbiter_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int CNT_W      = 8
) ();

    logic [N_REQ-1:0]            req;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0]            done;
    logic [FIFO_WIDTH-1:0]       data_in;
    logic                        wr_en;
    logic                        wr_ack;
    logic                        overflow;
    logic                        full;
    logic                        busy;
    logic [CNT_W-1:0]            retry_cnt;
    logic                        proto_err;

    modport master (
        input  req, req_data, wr_ack, overflow, full,
        output grant, done, data_in, wr_en, busy, retry_cnt, proto_err
    );

    modport slave (
        output req, req_data, wr_ack, overflow, full,
        input  grant, done, data_in, wr_en, busy, retry_cnt, proto_err
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after i_rr_ptr,
// wrapping modulo N_REQ (also for non-power-of-2 N_REQ).
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    // Walk the candidates farthest-first so the nearest requester overwrites last.
    always_comb begin
        int               w_pos;
        logic [PTR_W-1:0] w_cand;
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_pos   = int'(i_rr_ptr) + i;
            w_pos   = (w_pos >= N_REQ) ? (w_pos - N_REQ) : w_pos;
            w_cand  = PTR_W'(w_pos);
            o_idx   = i_req[w_cand] ? w_cand : o_idx;
            o_valid = o_valid | i_req[w_cand];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// with overflow retry, saturating retry counter and sticky protocol-error flag.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int N_REQ      = N_REQ_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [N_REQ-1:0]      r_grant;
    logic [N_REQ-1:0]      w_grant_nxt;
    logic [N_REQ-1:0]      r_done;
    logic [N_REQ-1:0]      w_done_nxt;
    logic [FIFO_WIDTH-1:0] r_data_in;
    logic [FIFO_WIDTH-1:0] w_data_nxt;
    logic                  r_wr_en;
    logic                  w_wr_en_nxt;
    logic                  r_busy;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_rr_ptr_nxt;
    logic [PTR_W-1:0]      r_idx;
    logic [PTR_W-1:0]      w_idx_nxt;
    logic [CNT_W-1:0]      r_retry_cnt;
    logic [CNT_W-1:0]      w_retry_nxt;
    logic [CNT_W-1:0]      w_retry_inc;
    logic                  r_proto_err;
    logic                  w_proto_nxt;
    logic                  w_pick_valid;
    logic [PTR_W-1:0]      w_pick_idx;
    logic [FIFO_WIDTH-1:0] w_pick_data;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_pick_data = bus.req_data[int'(w_pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    assign w_retry_inc = (&r_retry_cnt) ? r_retry_cnt : (r_retry_cnt + CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_data_nxt   = r_data_in;
        w_wr_en_nxt  = 1'b0;
        w_rr_ptr_nxt = r_rr_ptr;
        w_idx_nxt    = r_idx;
        w_retry_nxt  = r_retry_cnt;
        w_proto_nxt  = r_proto_err;
        case (r_state)
            IDLE: begin
                if (w_pick_valid && !bus.full) begin
                    w_state_nxt = ISSUE;
                    w_grant_nxt = N_REQ'(onehot(4'(w_pick_idx)));
                    w_data_nxt  = w_pick_data;
                    w_idx_nxt   = w_pick_idx;
                    w_wr_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A double response counts as accepted; a missing one as rejected.
                if (bus.wr_ack) begin
                    w_state_nxt  = IDLE;
                    w_done_nxt   = N_REQ'(onehot(4'(r_idx)));
                    w_rr_ptr_nxt = r_idx;
                    w_grant_nxt  = '0;
                    w_proto_nxt  = r_proto_err | bus.overflow;
                end else begin
                    w_state_nxt  = BLOCKED;
                    w_retry_nxt  = w_retry_inc;
                    w_proto_nxt  = r_proto_err | !bus.overflow;
                end
            end
            BLOCKED: begin
                if (!bus.full) begin
                    w_state_nxt = ISSUE;
                    w_wr_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = BLOCKED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_done      <= '0;
            r_data_in   <= '0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= PTR_W'(N_REQ - 1);
            r_idx       <= '0;
            r_retry_cnt <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_data_in   <= w_data_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_proto_err <= w_proto_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.data_in   = r_data_in;
    assign bus.wr_en     = r_wr_en;
    assign bus.busy      = r_busy;
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter against a depth-8 FIFO model whose
// response can be forced to overflow-only or to no response at all.
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst_n;
    logic fifo_rd;
    logic [1:0] fifo_mode;   // 0 normal, 1 force overflow, 2 no response
    logic m_ack;
    logic m_ovf;
    int   fcnt;
    logic [15:0] fq[$];
    int   n_vec;
    int   n_miss;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(16), .N_REQ(4), .CNT_W(8)) bus ();

    fifo_wr_arbiter #(.FIFO_WIDTH(16), .N_REQ(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FIFO: registered ack/overflow one cycle after wr_en.
    always @(posedge clk) begin
        m_ack <= 1'b0;
        m_ovf <= 1'b0;
        if (fifo_rd && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        if (bus.wr_en) begin
            if (fifo_mode == 2'd1) begin
                m_ovf <= 1'b1;
            end else if (fifo_mode == 2'd2) begin
                m_ovf <= 1'b0;
            end else if (fq.size() < 8) begin
                fq.push_back(bus.data_in);
                m_ack <= 1'b1;
            end else begin
                m_ovf <= 1'b1;
            end
        end
        fcnt <= fq.size();
    end

    assign bus.wr_ack   = m_ack;
    assign bus.overflow = m_ovf;
    assign bus.full     = (fcnt == 8);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        fcnt = 0;
        fifo_rd = 1'b0;
        fifo_mode = 2'd0;
        bus.req = 4'b0000;
        bus.req_data = 64'h0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_data", 32'(bus.data_in), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_retry", 32'(bus.retry_cnt), 32'h0);
        chk("rst_perr", 32'(bus.proto_err), 32'h0);
        chk("rst_rrptr", 32'(dut.r_rr_ptr), 32'h3);
        rst_n = 1'b1;

        // 1: single request, latency 1 to wr_en and 3 to done
        bus.req = 4'b0001;
        bus.req_data[15:0] = 16'hA5A5;
        tick();
        chk("t1_wr_en", 32'(bus.wr_en), 32'h1);
        chk("t1_grant", 32'(bus.grant), 32'h1);
        chk("t1_data", 32'(bus.data_in), 32'hA5A5);
        tick();
        chk("t1_wr_en_low", 32'(bus.wr_en), 32'h0);
        chk("t1_no_done", 32'(bus.done), 32'h0);
        tick();
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b0000;
        chk("t1_fifo", 32'(fq[0]), 32'hA5A5);

        // 2: fairness from reset with all four requesting
        rst_n = 1'b0;
        fifo_rd = 1'b1;
        tick();
        rst_n = 1'b1;
        fifo_rd = 1'b0;
        bus.req_data = {16'hB0B3, 16'hB0B2, 16'hB0B1, 16'hB0B0};
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_grant", 32'(bus.grant), 32'h1 << (i % 4));
            chk("t2_data", 32'(bus.data_in), 32'hB0B0 + 32'(i % 4));
            tick();
            tick();
            chk("t2_done", 32'(bus.done), 32'h1 << (i % 4));
        end
        chk("t2_full", 32'(bus.full), 32'h1);
        tick();
        chk("t2_hold_wr_en", 32'(bus.wr_en), 32'h0);
        chk("t2_hold_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            chk("t2_fifo_word", 32'(fq[i]), 32'hB0B0 + 32'(i % 4));
        end

        // 3: full FIFO holds off producer 2 until one read
        bus.req_data[47:32] = 16'hC3C3;
        bus.req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_wr_en", 32'(bus.wr_en), 32'h0);
            chk("t3_no_busy", 32'(bus.busy), 32'h0);
        end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        tick();
        chk("t3_wr_en", 32'(bus.wr_en), 32'h1);
        chk("t3_grant", 32'(bus.grant), 32'h4);
        chk("t3_data", 32'(bus.data_in), 32'hC3C3);
        tick();
        tick();
        chk("t3_done", 32'(bus.done), 32'h4);
        bus.req = 4'b0000;
        chk("t3_fifo_last", 32'(fq[7]), 32'hC3C3);

        // 4: forced overflow, retry with same word
        fifo_rd = 1'b1;
        repeat (8) tick();
        fifo_rd = 1'b0;
        fifo_mode = 2'd1;
        bus.req_data[31:16] = 16'h5A5A;
        bus.req = 4'b0010;
        tick();
        chk("t4_wr_en", 32'(bus.wr_en), 32'h1);
        tick();
        chk("t4_no_done_wait", 32'(bus.done), 32'h0);
        tick();
        chk("t4_busy", 32'(bus.busy), 32'h1);
        chk("t4_retry", 32'(bus.retry_cnt), 32'h1);
        chk("t4_grant_kept", 32'(bus.grant), 32'h2);
        chk("t4_no_done_blk", 32'(bus.done), 32'h0);
        fifo_mode = 2'd0;
        tick();
        chk("t4_reissue", 32'(bus.wr_en), 32'h1);
        chk("t4_same_data", 32'(bus.data_in), 32'h5A5A);
        tick();
        chk("t4_no_done_early", 32'(bus.done), 32'h0);
        tick();
        chk("t4_done", 32'(bus.done), 32'h2);
        bus.req = 4'b0000;
        chk("t4_fifo_cnt", 32'(fq.size()), 32'h1);

        // 5: reset while waiting for the FIFO response
        bus.req_data[15:0] = 16'h7777;
        bus.req = 4'b0001;
        tick();
        chk("t5_wr_en", 32'(bus.wr_en), 32'h1);
        tick();
        rst_n = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk("t5_grant", 32'(bus.grant), 32'h0);
        chk("t5_done", 32'(bus.done), 32'h0);
        chk("t5_wr_en0", 32'(bus.wr_en), 32'h0);
        chk("t5_data0", 32'(bus.data_in), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_retry", 32'(bus.retry_cnt), 32'h0);
        chk("t5_rrptr", 32'(dut.r_rr_ptr), 32'h3);
        rst_n = 1'b1;
        tick();
        chk("t5_no_late_done", 32'(bus.done), 32'h0);

        // 6: no response in WAIT sets sticky proto_err and retries
        fifo_mode = 2'd2;
        bus.req_data[63:48] = 16'h9999;
        bus.req = 4'b1000;
        tick();
        chk("t6_wr_en", 32'(bus.wr_en), 32'h1);
        chk("t6_grant", 32'(bus.grant), 32'h8);
        tick();
        tick();
        chk("t6_perr", 32'(bus.proto_err), 32'h1);
        chk("t6_retry", 32'(bus.retry_cnt), 32'h1);
        chk("t6_busy", 32'(bus.busy), 32'h1);
        fifo_mode = 2'd0;
        tick();
        chk("t6_reissue", 32'(bus.wr_en), 32'h1);
        chk("t6_data", 32'(bus.data_in), 32'h9999);
        tick();
        tick();
        chk("t6_done", 32'(bus.done), 32'h8);
        bus.req = 4'b0000;
        tick();
        chk("t6_perr_sticky", 32'(bus.proto_err), 32'h1);
        chk("t6_idle", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
